// File: rtl/sec32_pkg.sv
// Shared types and constants for the 32-bit SEC encoder front end.
// Holds the check-bit parity masks, the output word bundle and state enum.
package sec32_pkg;

  localparam int NUM_CHK  = 8;
  localparam int NUM_BITS = 40;

  localparam logic [31:0] CHK_MASK [NUM_CHK] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  check;
    logic        last;
  } sec32_word_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sec32_word_encoder_if.sv
// Byte-in / word-out bus of the SEC encoder plus the injector controls.
// master drives bytes, out_ready and inject requests; slave is the encoder.
interface sec32_word_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        inj_valid;
  logic [5:0]  inj_idx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        out_en;
  logic        out_last;
  logic        inj_armed;

  modport master (
    output in_valid, in_data, in_last,
    output inj_valid, inj_idx, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_check, out_en, out_last, inj_armed
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  inj_valid, inj_idx, out_ready,
    output in_ready, out_valid, out_data,
    output out_check, out_en, out_last, inj_armed
  );
endinterface

// File: rtl/sec32_checkgen.sv
// Combinational Hamming check-bit generator, even parity per mask group.
// data_i[31:0] -> check_o[7:0]; shared with the decoder reference model.
module sec32_checkgen
  import sec32_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [7:0]  check_o
);

  always_comb begin
    check_o = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      check_o[i] = ^(data_i & CHK_MASK[i]);
    end
  end

endmodule

// File: rtl/sec32_word_encoder.sv
// Packs a byte stream into 32-bit SEC words with check bits and an
// optional one-shot bit-flip injector. Ports: clk, rst, bus (slave).
module sec32_word_encoder
  import sec32_pkg::*;
#(
  parameter bit INJ_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sec32_word_encoder_if.slave bus
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  out_state_e  state_q, state_d;
  sec32_word_t word_q, word_d;
  logic        inj_armed_q, inj_armed_d;
  logic [5:0]  inj_idx_q, inj_idx_d;

  logic        completing;
  logic        in_fire;
  logic        load;
  logic        inj_req;
  logic [31:0] asm_word;
  logic [7:0]  asm_check;
  logic [39:0] flip;

  // Only the completing byte ever needs room in the output register.
  assign completing = (cnt_q == 2'd3) || bus.in_last;
  assign bus.in_ready = !(completing &&
                          (state_q == OUT_FULL) &&
                          !bus.out_ready);
  assign in_fire = bus.in_valid && bus.in_ready;
  assign load    = in_fire && completing;

  always_comb begin
    asm_word = acc_q;
    asm_word[{cnt_q, 3'b000} +: 8] = bus.in_data;
  end

  sec32_checkgen u_checkgen (
    .data_i  (asm_word),
    .check_o (asm_check)
  );

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (in_fire) begin
      if (completing) begin
        // Clearing acc here is what zero-pads a short final word.
        cnt_d = 2'd0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        acc_d = asm_word;
      end
    end
  end

  always_comb begin
    flip = '0;
    if (INJ_EN && inj_armed_q) begin
      flip = 40'd1 << inj_idx_q;
    end
    word_d = word_q;
    if (load) begin
      // Flip lands after check generation so the word is truly corrupt.
      {word_d.check, word_d.data} = {asm_check, asm_word} ^ flip;
      word_d.last = bus.in_last;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL: begin
        if (load)               state_d = OUT_FULL;
        else if (bus.out_ready) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    inj_req     = INJ_EN && bus.inj_valid && (bus.inj_idx < 6'd40);
    inj_armed_d = inj_armed_q;
    inj_idx_d   = inj_idx_q;
    if (load) begin
      inj_armed_d = 1'b0;
    end
    // A request in the load cycle re-arms for the following word.
    if (inj_req) begin
      inj_armed_d = 1'b1;
      inj_idx_d   = bus.inj_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      state_q     <= OUT_EMPTY;
      word_q      <= '0;
      inj_armed_q <= 1'b0;
      inj_idx_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      word_q      <= word_d;
      inj_armed_q <= inj_armed_d;
      inj_idx_q   <= inj_idx_d;
    end
  end

  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.out_en    = (state_q == OUT_FULL);
  assign bus.out_data  = word_q.data;
  assign bus.out_check = word_q.check;
  assign bus.out_last  = word_q.last;
  assign bus.inj_armed = inj_armed_q;

endmodule

// File: tb/tb_sec32_word_encoder.sv
// Self-checking bench for sec32_word_encoder with a packing/parity model.
// Drives bytes through the interface and compares every emitted word.
module tb_sec32_word_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sec32_word_encoder_if bus ();

  sec32_word_encoder #(.INJ_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] masks [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  typedef logic [7:0] bq_t [$];

  function automatic logic [7:0] ref_check(input logic [31:0] w);
    logic [7:0] c;
    for (int i = 0; i < 8; i++)
      c[i] = ($countones(w & masks[i]) % 2) == 1;
    return c;
  endfunction

  function automatic logic [31:0] ref_pack(input bq_t q);
    logic [31:0] w;
    w = 0;
    foreach (q[k]) w = w + (32'(q[k]) << (8 * k));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last,
                           output bit ok);
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.in_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
    bus.inj_valid = 0; bus.inj_idx = 0; bus.out_ready = 1;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    checks += 7;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    if (bus.out_en !== 1'b0) begin errors++;
      $display("FAIL rst_en got %b want 0", bus.out_en); end
    if (bus.out_data !== 32'h0) begin errors++;
      $display("FAIL rst_data got %h want 0", bus.out_data); end
    if (bus.out_check !== 8'h0) begin errors++;
      $display("FAIL rst_check got %h want 0", bus.out_check); end
    if (bus.out_last !== 1'b0) begin errors++;
      $display("FAIL rst_last got %b want 0", bus.out_last); end
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got %b want 1", bus.in_ready); end
    if (bus.inj_armed !== 1'b0) begin errors++;
      $display("FAIL rst_armed got %b want 0", bus.inj_armed); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] v [4];
    v = '{8'h01, 8'h00, 8'h00, 8'h00};
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[i], 1'b0, ok);
      checks++;
      if (!ok) begin errors++;
        $display("FAIL basic_accept got timeout want accept"); end
    end
    checks += 5;
    if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL basic_valid got %b want 1", bus.out_valid); end
    if (bus.out_en !== 1'b1) begin errors++;
      $display("FAIL basic_en got %b want 1", bus.out_en); end
    if (bus.out_data !== 32'h00000001) begin errors++;
      $display("FAIL basic_data got %h want 00000001", bus.out_data); end
    if (bus.out_check !== 8'h51) begin errors++;
      $display("FAIL basic_check got %h want 51", bus.out_check); end
    if (bus.out_last !== 1'b0) begin errors++;
      $display("FAIL basic_last got %b want 0", bus.out_last); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL basic_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [31:0] w;
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      b = (i < 4) ? 8'hFF : 8'h00;
      bus.in_valid = 1; bus.in_data = b; bus.in_last = 0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++;
        $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.in_ready); end
      tick();
      if (i == 3 || i == 7) begin
        w = (i == 3) ? 32'hFFFFFFFF : 32'h0;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++;
          $display("FAIL b2b_valid[%0d] got %b want 1", i, bus.out_valid); end
        if (bus.out_data !== w) begin errors++;
          $display("FAIL b2b_data[%0d] got %h want %h", i, bus.out_data, w); end
        if (bus.out_check !== 8'h00) begin errors++;
          $display("FAIL b2b_check[%0d] got %h want 00", i, bus.out_check); end
      end
    end
    bus.in_valid = 0;
    tick();
  endtask

  task automatic test_stall();
    bit ok;
    bq_t qa, qb;
    logic [7:0] seq [5];
    logic [31:0] wa, wb;
    int idx, cnt;
    logic exp_rdy, acc;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(8'($urandom));
      send_byte(qa[i], 1'b0, ok);
    end
    wa = ref_pack(qa);
    for (int i = 0; i < 5; i++) seq[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) qb.push_back(seq[i]);
    wb = ref_pack(qb);
    bus.out_ready = 0;
    idx = 0; cnt = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1; bus.in_data = seq[idx]; bus.in_last = (idx == 4);
      #1;
      exp_rdy = (cnt != 3);
      acc = bus.in_ready;
      checks++;
      if (bus.in_ready !== exp_rdy) begin errors++;
        $display("FAIL stall_ready[%0d] got %b want %b", c, bus.in_ready, exp_rdy); end
      tick();
      checks += 3;
      if (bus.out_valid !== 1'b1) begin errors++;
        $display("FAIL stall_valid[%0d] got %b want 1", c, bus.out_valid); end
      if (bus.out_data !== wa) begin errors++;
        $display("FAIL stall_data[%0d] got %h want %h", c, bus.out_data, wa); end
      if (bus.out_check !== ref_check(wa)) begin errors++;
        $display("FAIL stall_check[%0d] got %h want %h", c, bus.out_check, ref_check(wa)); end
      if (acc === 1'b1) begin idx++; cnt = (cnt + 1) % 4; end
    end
    bus.out_ready = 1;
    bus.in_data = seq[idx]; bus.in_last = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL stall_b_valid got %b want 1", bus.out_valid); end
    if (bus.out_data !== wb) begin errors++;
      $display("FAIL stall_b_data got %h want %h", bus.out_data, wb); end
    if (bus.out_check !== ref_check(wb)) begin errors++;
      $display("FAIL stall_b_check got %h want %h", bus.out_check, ref_check(wb)); end
    send_byte(seq[4], 1'b1, ok);
    checks += 3;
    if (bus.out_data !== {24'h0, seq[4]}) begin errors++;
      $display("FAIL stall_c_data got %h want %h", bus.out_data, {24'h0, seq[4]}); end
    if (bus.out_last !== 1'b1) begin errors++;
      $display("FAIL stall_c_last got %b want 1", bus.out_last); end
    if (!ok) begin errors++;
      $display("FAIL stall_c_accept got timeout want accept"); end
    tick();
  endtask

  task automatic test_last_flush();
    bit ok;
    logic [31:0] w;
    bus.out_ready = 1;
    send_byte(8'hAB, 1'b1, ok);
    w = 32'h000000AB;
    checks += 4;
    if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL flush_valid got %b want 1", bus.out_valid); end
    if (bus.out_data !== w) begin errors++;
      $display("FAIL flush_data got %h want %h", bus.out_data, w); end
    if (bus.out_check !== ref_check(w)) begin errors++;
      $display("FAIL flush_check got %h want %h", bus.out_check, ref_check(w)); end
    if (bus.out_last !== 1'b1) begin errors++;
      $display("FAIL flush_last got %b want 1", bus.out_last); end
    tick();
  endtask

  task automatic test_random_msgs();
    bit ok;
    bq_t q;
    int len;
    logic [7:0] b;
    logic last;
    logic [31:0] w;
    bus.out_ready = 1;
    for (int m = 0; m < 20; m++) begin
      len = $urandom_range(1, 9);
      q.delete();
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        last = (j == len - 1);
        q.push_back(b);
        send_byte(b, last, ok);
        if (q.size() == 4 || last) begin
          w = ref_pack(q);
          checks += 4;
          if (bus.out_valid !== 1'b1 || !ok) begin errors++;
            $display("FAIL rnd_valid[%0d] got %b want 1", m, bus.out_valid); end
          if (bus.out_data !== w) begin errors++;
            $display("FAIL rnd_data[%0d] got %h want %h", m, bus.out_data, w); end
          if (bus.out_check !== ref_check(w)) begin errors++;
            $display("FAIL rnd_check[%0d] got %h want %h", m, bus.out_check, ref_check(w)); end
          if (bus.out_last !== last) begin errors++;
            $display("FAIL rnd_last[%0d] got %b want %b", m, bus.out_last, last); end
          q.delete();
        end
      end
    end
    tick();
  endtask

  task automatic test_inject();
    bit ok;
    bq_t q;
    logic [5:0] idx;
    logic [31:0] w;
    logic [39:0] exp;
    bus.out_ready = 1;
    bus.inj_valid = 1; bus.inj_idx = 6'd0;
    tick();
    bus.inj_valid = 0;
    checks++;
    if (bus.inj_armed !== 1'b1) begin errors++;
      $display("FAIL inj_armed got %b want 1", bus.inj_armed); end
    send_byte(8'h01, 0, ok); send_byte(8'h00, 0, ok);
    send_byte(8'h00, 0, ok); send_byte(8'h00, 0, ok);
    checks += 3;
    if (bus.out_data !== 32'h0) begin errors++;
      $display("FAIL inj0_data got %h want 00000000", bus.out_data); end
    if (bus.out_check !== 8'h51) begin errors++;
      $display("FAIL inj0_check got %h want 51", bus.out_check); end
    if (bus.inj_armed !== 1'b0) begin errors++;
      $display("FAIL inj0_clear got %b want 0", bus.inj_armed); end
    bus.inj_valid = 1; bus.inj_idx = 6'd45;
    tick();
    bus.inj_valid = 0;
    checks++;
    if (bus.inj_armed !== 1'b0) begin errors++;
      $display("FAIL inj45_armed got %b want 0", bus.inj_armed); end
    for (int r = 0; r < 8; r++) begin
      idx = 6'($urandom_range(0, 39));
      bus.inj_valid = 1; bus.inj_idx = 6'($urandom_range(0, 39));
      tick();
      bus.inj_idx = idx;
      tick();
      bus.inj_valid = 0;
      q.delete();
      for (int j = 0; j < 4; j++) begin
        q.push_back(8'($urandom));
        send_byte(q[j], 0, ok);
      end
      w = ref_pack(q);
      exp = {ref_check(w), w} ^ (40'd1 << idx);
      checks += 3;
      if (bus.out_data !== exp[31:0]) begin errors++;
        $display("FAIL injr_data[%0d] got %h want %h", r, bus.out_data, exp[31:0]); end
      if (bus.out_check !== exp[39:32]) begin errors++;
        $display("FAIL injr_check[%0d] got %h want %h", r, bus.out_check, exp[39:32]); end
      if (bus.inj_armed !== 1'b0) begin errors++;
        $display("FAIL injr_clear[%0d] got %b want 0", r, bus.inj_armed); end
    end
    q.delete();
    for (int j = 0; j < 3; j++) begin
      q.push_back(8'($urandom));
      send_byte(q[j], 0, ok);
    end
    q.push_back(8'($urandom));
    bus.inj_valid = 1; bus.inj_idx = 6'd7;
    send_byte(q[3], 0, ok);
    bus.inj_valid = 0;
    w = ref_pack(q);
    checks += 3;
    if (bus.out_data !== w) begin errors++;
      $display("FAIL injsame_data got %h want %h", bus.out_data, w); end
    if (bus.out_check !== ref_check(w)) begin errors++;
      $display("FAIL injsame_check got %h want %h", bus.out_check, ref_check(w)); end
    if (bus.inj_armed !== 1'b1) begin errors++;
      $display("FAIL injsame_armed got %b want 1", bus.inj_armed); end
    q.delete();
    for (int j = 0; j < 4; j++) begin
      q.push_back(8'($urandom));
      send_byte(q[j], 0, ok);
    end
    w = ref_pack(q) ^ 32'h80;
    checks++;
    if (bus.out_data !== w) begin errors++;
      $display("FAIL injnext_data got %h want %h", bus.out_data, w); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bq_t q;
    logic [31:0] w;
    bus.out_ready = 0;
    for (int j = 0; j < 6; j++) send_byte(8'($urandom), 0, ok);
    bus.inj_valid = 1; bus.inj_idx = 6'd3;
    tick();
    bus.inj_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
    if (bus.out_data !== 32'h0) begin errors++;
      $display("FAIL rmid_data got %h want 0", bus.out_data); end
    if (bus.inj_armed !== 1'b0) begin errors++;
      $display("FAIL rmid_armed got %b want 0", bus.inj_armed); end
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL rmid_ready got %b want 1", bus.in_ready); end
    bus.out_ready = 1;
    for (int j = 0; j < 4; j++) begin
      q.push_back(8'($urandom));
      send_byte(q[j], 0, ok);
      if (j < 3) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++;
          $display("FAIL rmid_early[%0d] got %b want 0", j, bus.out_valid); end
      end
    end
    w = ref_pack(q);
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL rmid_word_valid got %b want 1", bus.out_valid); end
    if (bus.out_data !== w) begin errors++;
      $display("FAIL rmid_word_data got %h want %h", bus.out_data, w); end
    if (bus.out_check !== ref_check(w)) begin errors++;
      $display("FAIL rmid_word_check got %h want %h", bus.out_check, ref_check(w)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_last_flush();
    test_random_msgs();
    test_inject();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sec32_word_encoder.md
# sec32_word_encoder

Byte-serial front end for the 32-bit single-error-correcting (SEC) decoder. It packs an incoming byte stream into 32-bit words and computes the 8 Hamming check bits with the decoder's exact parity groups. It presents `{data, check, enable}` to the decoder through a registered valid/ready output stage. It also carries a one-shot single-bit error injector so the decoder's correction path can be exercised in system.

## Interface
- `INJ_EN`, default 1: 1 = error injector present; 0 = inject port ignored (tied off).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: byte valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `in_data` in 8: payload byte, little-endian (first byte → `d[7:0]`).
- `in_last` in 1: final byte of a message; flushes a partial word.
- `inj_valid` in 1: pulse that arms the injector.
- `inj_idx` in 6: bit to flip. 0–31 = data bit, 32–39 = check bit `idx-32`.
- `out_valid` out 1: word valid.
- `out_ready` in 1: decoder stage accepts.
- `out_data` out 32: `d[31:0]` (`d[k]` feeds decoder input k, in port order).
- `out_check` out 8: `c[7:0]` (`c[i]` feeds decoder check input i).
- `out_en` out 1: decoder syndrome enable. Equals `out_valid`.
- `out_last` out 1: word ends a message.
- `inj_armed` out 1: an injection is pending.

## Operation
- Assembler: counter `cnt[1:0]` and shift register `acc[31:0]`.
  - An accepted byte is written to `acc[8*cnt +: 8]`, then `cnt` increments.
  - The word completes when `cnt==3` or `in_last` is set on an accepted byte.
  - Missing upper bytes are zero-padded. `cnt` returns to 0.
- Check bits: `c[i] = ^(word & CHK_MASK[i])`, even parity, computed combinationally on the completed word.
  - `CHK_MASK` = {0x00FF1111, 0xFF002222, 0x0F0F4444, 0xF0F08888, 0x111100FF, 0x2222FF00, 0x44440F0F, 0x8888F0F0} for i = 0..7.
- Output register states:
  - EMPTY → FULL when a word completes.
  - FULL → EMPTY on `out_ready` with no new completion.
  - FULL → FULL when handshake and completion happen in the same cycle (back-to-back words).
- `in_ready = !(word_completing_byte_position && FULL && !out_ready)`.
  - Bytes 0–2 are always accepted.
  - The completing byte stalls only while the output register is blocked.
- Injector:
  - `inj_valid` with `inj_idx < 40` sets `inj_armed` and latches the index.
  - `inj_idx >= 40` is ignored.
  - The next word loaded into the output register has exactly that bit inverted, after check generation. Then `inj_armed` clears in the same cycle as the load.
  - A new `inj_valid` while armed overwrites the index.
  - If `inj_valid` arrives in the same cycle as a load, the current load is not affected and the new request arms for the next word.
- Reset: `cnt=0`, `acc=0`, `inj_armed=0`, output EMPTY.
  - Outputs after reset: `out_valid=0`, `out_en=0`, `out_data=0`, `out_check=0`, `out_last=0`, `in_ready=1`.

## Timing
- Latency: completing byte accepted at edge t → `out_valid=1` with the word after edge t.
- Throughput: 1 word per 4 byte cycles. No bubbles while `out_ready=1`.
- Output fields stay stable while `out_valid && !out_ready`. Changing them in that case is a protocol violation that the bench asserts on.
- `in_last` with `cnt==3` is an ordinary completion with `out_last=1`.
- `in_last` on an idle word (`cnt==0`) emits a word containing that byte only.
- `rst` mid-word discards the partial word and any pending injection. A word held in the output register is dropped.

## Structure
- `sec32_pkg` holds:
  - `CHK_MASK` constant array.
  - `sec32_word_t` struct `{data[31:0], check[7:0], last}`.
  - `NUM_CHK=8`, `NUM_BITS=40`.
- Sub-module `sec32_checkgen` (combinational): `data[31:0]` → `check[7:0]`. It is reused by the decoder bench's reference model.
- The top level holds the assembler, the output register and the injector.

## Test plan
- Bytes 0x01,0x00,0x00,0x00 → `out_data=0x00000001`, `out_check=0x51`, `out_en=1`, one cycle after the 4th byte.
- Bytes 0xFF×4, then 0x00×4 back-to-back with `out_ready=1` → words 0xFFFFFFFF/chk 0x00 and 0x00000000/chk 0x00. `in_ready` stays 1 throughout.
- `out_ready=0` for 6 cycles while 5 more bytes arrive → the 4th byte stalls (`in_ready=0`) and the output stays stable. After release, both words come out in order.
- Byte 0xAB with `in_last=1` at `cnt==0` → `out_data=0x000000AB`, `out_last=1`, `out_check=parity(0xAB & mask)`.
- `inj_idx=0`, then word 0x00000001 → `out_data=0x00000000`, `out_check=0x51`. The decoder restores 0x00000001, and `inj_armed` clears.
- `inj_idx=45` is ignored (`inj_armed=0`). `rst` after 2 bytes → the next 4 bytes form a clean word and `cnt` restarts at 0.
